// File: rtl/bin2bcd_hex_feeder.sv
// bin2bcd_hex_feeder: double-dabble binary-to-BCD converter that pushes six digits into the hex display block.
// Define HEX_BYPASS_EN to let VALUE writes with bit 31 set push writeData[23:0] without conversion.
module bin2bcd_hex_feeder #(
    parameter int BIN_WIDTH = 20,
    parameter int DIGITS    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        chipSelect,
    input  logic        write,
    input  logic        read,
    input  logic        address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        hexChipSelect,
    output logic        hexWrite,
    output logic [31:0] hexWriteData
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam logic [31:0] MAXV = 32'(10 ** DIGITS - 1);
`ifdef HEX_BYPASS_EN
    localparam int PW = 32;
`else
    localparam int PW = BIN_WIDTH;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;
    state_t state, state_nx;

    logic [BIN_WIDTH-1:0] bin, last_val;
    logic [BW-1:0]        bcd, bcd_adj, load_bcd;
    logic [CW-1:0]        cnt;
    logic [PW-1:0]        pend_word, load_word;
    logic pending, overflow, done, ovf_cur;
    logic val_wr, stat_wr, stat_rd, load, byp, last_iter, unused_bits;

    assign val_wr    = chipSelect & write & ~address;
    assign stat_wr   = chipSelect & write & address;
    assign stat_rd   = chipSelect & read & address;
    assign last_iter = (state == SHIFT) && (cnt == CW'(BIN_WIDTH));

`ifdef HEX_BYPASS_EN
    // a bypass load pre-fills the digits and a finished counter, so SHIFT lasts one cycle
    assign byp         = load_word[31];
    assign load_bcd    = byp ? load_word[BW-1:0] : '0;
    assign unused_bits = ^load_word[30:BW];
`else
    assign byp         = 1'b0;
    assign load_bcd    = '0;
    assign unused_bits = ^writeData[31:BIN_WIDTH];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        load_word = writeData[PW-1:0];
        case (state)
            IDLE: begin
                state_nx = val_wr ? SHIFT : IDLE;
                load     = val_wr;
            end
            SHIFT: state_nx = last_iter ? PUSH : SHIFT;
            default: begin
                state_nx  = (val_wr || pending) ? SHIFT : IDLE;
                load      = val_wr || pending;
                load_word = val_wr ? writeData[PW-1:0] : pend_word;
            end
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++)
            bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin           <= '0;
            bcd           <= '0;
            cnt           <= '0;
            ovf_cur       <= 1'b0;
            pend_word     <= '0;
            pending       <= 1'b0;
            overflow      <= 1'b0;
            done          <= 1'b0;
            last_val      <= '0;
            hexChipSelect <= 1'b0;
            hexWrite      <= 1'b0;
            hexWriteData  <= '0;
        end else begin
            if (val_wr) last_val <= writeData[BIN_WIDTH-1:0];
            if (load) begin
                bin     <= load_word[BIN_WIDTH-1:0];
                bcd     <= load_bcd;
                cnt     <= byp ? CW'(BIN_WIDTH) : '0;
                ovf_cur <= ~byp && (32'(load_word[BIN_WIDTH-1:0]) > MAXV);
            end else if (state == SHIFT && !last_iter) begin
                {bcd, bin} <= {bcd_adj, bin} << 1;
                cnt        <= cnt + 1'b1;
            end
            if (state == SHIFT && val_wr) begin
                pending   <= 1'b1;
                pend_word <= writeData[PW-1:0];
            end else if (state == PUSH) begin
                pending <= 1'b0;
            end
            hexChipSelect <= last_iter;
            hexWrite      <= last_iter;
            if (last_iter) hexWriteData <= 32'(ovf_cur ? {DIGITS{4'hE}} : bcd);
            done     <= (state == PUSH) || (done && !(stat_rd || stat_wr));
            overflow <= (state == PUSH) ? ovf_cur : overflow && !stat_wr;
        end
    end

    assign readData = !(chipSelect && read) ? 32'h0
                    : address ? {28'h0, done, overflow, pending, state != IDLE}
                    : 32'(last_val);
endmodule

// File: tb/tb_bin2bcd_hex_feeder.sv
// tb_bin2bcd_hex_feeder: vectors, corner sequences and random writes against a decimal reference model.
module tb_bin2bcd_hex_feeder;
    logic        clk = 0, rst = 0, chipSelect = 0, write = 0, read = 0, address = 0;
    logic [31:0] writeData = 0;
    logic [31:0] readData, hexWriteData;
    logic        hexChipSelect, hexWrite;

    bin2bcd_hex_feeder dut (
        .clk(clk), .rst(rst), .chipSelect(chipSelect), .write(write), .read(read),
        .address(address), .writeData(writeData), .readData(readData),
        .hexChipSelect(hexChipSelect), .hexWrite(hexWrite), .hexWriteData(hexWriteData)
    );

    always #5 clk = ~clk;

    int cyc = 0, total = 0, bad = 0;
    int got_c[$];
    logic [31:0] got_d[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (rst && hexWrite) begin
        got_d.push_back(hexWriteData);
        got_c.push_back(cyc);
        check("hexcs", 32'(hexChipSelect), 32'd1);
    end

    // {overflow, pushed word}: decimal digits by repeated division
    function automatic logic [32:0] model(logic [31:0] wd);
        logic [31:0] v, r;
        r = 0;
`ifdef HEX_BYPASS_EN
        if (wd[31]) return {1'b0, 8'h0, wd[23:0]};
`endif
        v = wd & 32'hFFFFF;
        if (v > 999999) return {1'b1, 32'h00EEEEEE};
        for (int i = 0; i < 6; i++) begin
            r |= (v % 10) << (4 * i);
            v /= 10;
        end
        return {1'b0, r};
    endfunction

    function automatic int lat(logic [31:0] wd);
`ifdef HEX_BYPASS_EN
        if (wd[31]) return 1;
`endif
        return 21;
    endfunction

    task automatic write_reg(bit a, logic [31:0] d, output int c);
        @(negedge clk);
        chipSelect = 1; write = 1; address = a; writeData = d;
        @(posedge clk); #1;
        c = cyc;
        chipSelect = 0; write = 0; writeData = 0;
    endtask

    task automatic read_reg(bit a, output logic [31:0] d);
        @(negedge clk);
        chipSelect = 1; read = 1; address = a;
        #1 d = readData;
        @(posedge clk); #1;
        chipSelect = 0; read = 0;
    endtask

    task automatic wait_push(string name, output logic [31:0] d, output int c);
        int n = 0;
        while (got_d.size() == 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (got_d.size() == 0) begin
            check({name, " timeout"}, 32'd0, 32'd1);
            d = 'x;
            c = -1;
        end else begin
            d = got_d.pop_front();
            c = got_c.pop_front();
        end
    endtask

    // one write, one push, one status read
    task automatic single(string name, logic [31:0] wd);
        int a, c;
        logic [31:0] d, s;
        logic [32:0] m;
        m = model(wd);
        write_reg(0, wd, a);
        wait_push(name, d, c);
        check({name, " data"}, d, m[31:0]);
        check({name, " lat"}, 32'(c - a), 32'(lat(wd)));
        read_reg(1, s);
        check({name, " status"}, s, {28'h0, 1'b1, m[32], 2'b00});
    endtask

    typedef struct {
        logic [31:0] wd;
        logic [31:0] push;
        logic        ovf;
        int          lat;
    } vec_t;
    vec_t vecs[8];

    initial begin
        int a, c, c1, k1, k2;
        logic [31:0] d, s, va, vb, vc;
        logic [32:0] m;

        vecs[0] = '{32'd0,        32'h00000000, 1'b0, 21};
        vecs[1] = '{32'd999999,   32'h00999999, 1'b0, 21};
        vecs[2] = '{32'd1000000,  32'h00EEEEEE, 1'b1, 21};
        vecs[3] = '{32'd1048575,  32'h00EEEEEE, 1'b1, 21};
        vecs[4] = '{32'h7FF00009, 32'h00000009, 1'b0, 21};
        vecs[5] = '{32'd100000,   32'h00100000, 1'b0, 21};
`ifdef HEX_BYPASS_EN
        vecs[6] = '{32'h80ABCDEF, 32'h00ABCDEF, 1'b0, 1};
`else
        vecs[6] = '{32'h80ABCDEF, 32'h00773615, 1'b0, 21};
`endif
        vecs[7] = '{32'd1,        32'h00000001, 1'b0, 21};

        rst = 0;
        repeat (6) begin
            @(negedge clk);
            chipSelect = ~chipSelect; write = 1; writeData = 32'd123;
        end
        @(negedge clk);
        chipSelect = 1; write = 0; read = 1; address = 1;
        #1;
        check("rst status", readData, 32'h0);
        check("rst hexcs", 32'(hexChipSelect), 32'h0);
        check("rst hexwr", 32'(hexWrite), 32'h0);
        check("rst hexdata", hexWriteData, 32'h0);
        chipSelect = 0; read = 0; address = 0; writeData = 0;
        @(negedge clk) rst = 1;

        write_reg(0, 32'd123456, a);
        wait_push("p123456", d, c);
        check("p123456 data", d, 32'h00123456);
        check("p123456 lat", 32'(c - a), 32'd21);
        repeat (3) @(posedge clk);
        check("p123456 oneshot", 32'(got_d.size()), 32'd0);
        read_reg(1, s);
        check("p123456 status", s, 32'h8);
        read_reg(1, s);
        check("p123456 cleared", s, 32'h0);
        read_reg(0, s);
        check("p123456 value", s, 32'd123456);

        foreach (vecs[i]) begin
            write_reg(0, vecs[i].wd, a);
            wait_push($sformatf("vec%0d", i), d, c);
            check($sformatf("vec%0d data", i), d, vecs[i].push);
            check($sformatf("vec%0d lat", i), 32'(c - a), 32'(vecs[i].lat));
            read_reg(1, s);
            check($sformatf("vec%0d status", i), s, {28'h0, 1'b1, vecs[i].ovf, 2'b00});
        end

        write_reg(0, 32'd1000000, a);
        wait_push("ovfclr", d, c);
        check("ovfclr data", d, 32'h00EEEEEE);
        write_reg(1, 32'hF, a);
        read_reg(1, s);
        check("ovfclr status", s, 32'h0);

        // status read on the PUSH edge: done still sets
        write_reg(0, 32'd31, a);
        repeat (20) @(posedge clk);
        read_reg(1, s);
        check("setwins busy", s, 32'h1);
        wait_push("setwins", d, c);
        check("setwins data", d, 32'h00000031);
        read_reg(1, s);
        check("setwins status", s, 32'h8);

        write_reg(0, 32'd42, a);
        repeat (4) @(posedge clk);
        write_reg(0, 32'd7, c);
        repeat (2) @(posedge clk);
        write_reg(0, 32'd9, c);
        read_reg(1, s);
        check("pend status", s, 32'h3);
        wait_push("pend1", d, c1);
        check("pend1 data", d, 32'h00000042);
        check("pend1 lat", 32'(c1 - a), 32'd21);
        wait_push("pend2", d, c);
        check("pend2 data", d, 32'h00000009);
        check("pend2 lat", 32'(c - c1), 32'd22);
        repeat (25) @(posedge clk);
        check("pend extra", 32'(got_d.size()), 32'd0);
        read_reg(1, s);
        check("pend done", s, 32'h8);

        write_reg(0, 32'd77, a);
        repeat (9) @(posedge clk);
        #2 rst = 0;
        chipSelect = 1; read = 1; address = 1;
        #1;
        check("abort status", readData, 32'h0);
        check("abort hexwr", 32'(hexWrite), 32'h0);
        check("abort hexdata", hexWriteData, 32'h0);
        chipSelect = 0; read = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1;
        repeat (30) @(posedge clk);
        check("abort nopush", 32'(got_d.size()), 32'd0);
        single("after abort", 32'd5);

        for (int i = 0; i < 12; i++)
            single($sformatf("rnd%0d", i),
                   ($urandom_range(0, 3) == 0) ? 32'd999990 + $urandom_range(0, 20) : $urandom);

        for (int i = 0; i < 3; i++) begin
            va = $urandom & 32'h7FFFFFFF;
            vb = $urandom;
            vc = $urandom;
            k1 = $urandom_range(1, 10);
            k2 = $urandom_range(k1 + 1, 21);
            write_reg(0, va, a);
            repeat (k1 - 1) @(posedge clk);
            write_reg(0, vb, c);
            repeat (k2 - k1 - 1) @(posedge clk);
            write_reg(0, vc, c);
            m = model(va);
            wait_push($sformatf("rpend%0d a", i), d, c1);
            check($sformatf("rpend%0d a data", i), d, m[31:0]);
            check($sformatf("rpend%0d a lat", i), 32'(c1 - a), 32'd21);
            m = model(vc);
            wait_push($sformatf("rpend%0d c", i), d, c);
            check($sformatf("rpend%0d c data", i), d, m[31:0]);
            check($sformatf("rpend%0d c lat", i), 32'(c - c1), 32'(1 + lat(vc)));
            repeat (3) @(posedge clk);
            check($sformatf("rpend%0d extra", i), 32'(got_d.size()), 32'd0);
            read_reg(1, s);
            check($sformatf("rpend%0d status", i), s, {28'h0, 1'b1, m[32], 2'b00});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
